// File: rtl/rr_arbiter_4_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4_pkg
// Shared constants, the FSM state encoding and the 2-to-4 one-hot decode
// used by the four-requester round-robin arbiter.
// ----------------------------------------------------------------------------
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Binary index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] dec_idx(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin search. Scans req at last_idx+1, +2, +3, +4
// (modulo 4) and reports the first set bit.
//   req_i      : request vector
//   excl_i     : when set, req[last_idx] is ignored (owner cannot re-win)
//   last_idx_i : search origin; its successor has top priority
//   found_o    : some eligible request exists
//   idx_o      : index of the winner (0 when found_o=0)
// ----------------------------------------------------------------------------
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             excl_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] cand;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    masked  = req_i;
    if (excl_i) masked[last_idx_i] = 1'b0;
    // Walk from the farthest candidate to the nearest so the nearest set bit
    // is the last one written and therefore wins. The 2-bit sum wraps 3->0.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_idx_i + IDX_W'(k);
      if (masked[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
// Four-requester round-robin arbiter with an optional hold limit.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req       : request vector, bit i = requester i
//   gnt       : registered one-hot grant, zero when idle
//   gnt_idx   : registered owner index, meaningful only while gnt_valid=1
//   gnt_valid : registered, equals |gnt
//   preempt   : one-cycle pulse on the first cycle of a grant that was won
//               by hold-limit preemption
// Parameters:
//   MAX_HOLD  : max consecutive grant cycles while others wait (0 = no limit)
//   CNT_W     : hold counter width, 2**CNT_W > MAX_HOLD
// ----------------------------------------------------------------------------
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam bit               LIMIT_EN  = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = LIMIT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, preempt_q, preempt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             in_grant;

  // While granting, search from the current owner and mask it out: on a
  // release its bit is already low, on a preemption it must not re-win.
  assign in_grant = (state_q == GRANT);

  rr_pick4 u_pick (
    .req_i      (req),
    .excl_i     (in_grant),
    .last_idx_i (in_grant ? idx_q : last_idx_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          idx_d      = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Release: hand over on the same edge when someone else waits.
          last_idx_d = idx_q;
          hold_cnt_d = '0;
          if (pick_found) idx_d = pick_idx;
          else            state_d = IDLE;
        end else if (LIMIT_EN && (hold_cnt_q == HOLD_LAST) && pick_found) begin
          last_idx_d = idx_q;
          idx_d      = pick_idx;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
        end else if (LIMIT_EN && (hold_cnt_q != HOLD_LAST)) begin
          // Counter saturates at HOLD_LAST so a sole requester holds forever
          // yet is preempted as soon as a competitor shows up.
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Decode the next index before the register so gnt never glitches.
    gnt_d = (state_d == GRANT) ? dec_idx(idx_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_idx_q <= IDX_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      valid_q    <= (state_d == GRANT);
      preempt_q  <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule
